// File: rtl/enc4to2_seq.sv
// enc4to2_seq: registered 4-to-2 request encoder with a valid/ready output.
// Request pulses on A are merged into a sticky pending set and handed out
// one 2-bit code per transfer. Re-requesting a bit that is still pending
// produces a one-cycle DROP pulse, because the duplicate is merged.
// Optional feature macro: ROUND_ROBIN_EN (rotating priority). When it is
// undefined, the highest pending index wins.
module enc4to2_seq #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E,
  input  logic [N-1:0] A,
  output logic [W-1:0] Y,
  output logic         V,
  input  logic         R,
  output logic         DROP,
  output logic         BUSY
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] pend;
  logic [N-1:0] pend_nxt;
  logic [N-1:0] cap;
  logic [N-1:0] clr;
  logic         load;
  logic         drop_nxt;
  logic [W-1:0] win;

  // Fixed priority: the highest set index wins.
  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] p);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) idx = i[W-1:0];
    end
    return idx;
  endfunction

  // Rotating priority: search upward from last+1, wrapping, with last checked last.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] p, input logic [W-1:0] last);
    logic [W-1:0] idx;
    logic [W-1:0] j;
    logic         found;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = last + k[W-1:0];
      if (!found && p[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Binary index to the one-hot bit that is cleared from the pending set.
  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] o;
    o      = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] last;

  // Last-granted pointer; starts at N-1 so that index 0 is searched first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= W'(N - 1);
    end else if (load) begin
      last <= win;
    end
  end

  assign win = sel_rr(pend, last);
`else
  assign win = sel_fixed(pend);
`endif

  // Next state, grant/clear decision, capture and duplicate detection.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (R) begin
          if (|pend) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    clr      = load ? onehot(win) : '0;
    cap      = E ? A : '0;
    // Set wins over clear: a new request on the bit being granted stays pending.
    pend_nxt = (pend & ~clr) | cap;
    drop_nxt = |(cap & pend & ~clr);
  end

  // State, pending set, output code and the DROP pulse register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      Y     <= '0;
      DROP  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      DROP  <= drop_nxt;
      if (load) begin
        Y <= win;
      end
    end
  end

  assign V    = (state == HOLD);
  assign BUSY = (|pend) | V;

endmodule
